cpu_inst_encoder: RTL and testbench

//  Program loader that encodes LEGv8 instructions for the CPU under test: takes mnemonic-level

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/inst_pack.sv | 37 +++
 rtl/cpu_inst_encoder.sv | 135 +++++++++++++
 tb/tb_cpu_inst_encoder.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8 instruction path: the command op encoding seen by the
// program loader and the 11-bit opcode constants that the control decoder recognises.
package cpu_pkg;

  // Loader command ops (3-bit in_op field).
  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_AND     = 3'd2,
    OP_ORR     = 3'd3,
    OP_LDUR    = 3'd4,
    OP_STUR    = 3'd5,
    OP_HALT    = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  // 11-bit opcodes occupying instruction bits [31:21].
  localparam logic [10:0] OPC_ADD  = 11'h458;
  localparam logic [10:0] OPC_SUB  = 11'h658;
  localparam logic [10:0] OPC_AND  = 11'h450;
  localparam logic [10:0] OPC_ORR  = 11'h550;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [10:0] OPC_HALT = 11'h7FF;

endpackage

// File: rtl/inst_pack.sv
// Combinational instruction packer: op + register/offset fields -> {legal, 32-bit word}.
// Ports:
//   i_op    command op (cpu_pkg::op_e encoding)
//   i_rd    Rd (R-format) / Rt (D-format)
//   i_rn    Rn
//   i_rm    Rm (R-format only)
//   i_dt    DT_address (D-format only)
//   o_legal op is one the control decoder understands
//   o_word  packed instruction word (zero when illegal)
module inst_pack
  import cpu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rn,
  input  logic [4:0]  i_rm,
  input  logic [8:0]  i_dt,
  output logic        o_legal,
  output logic [31:0] o_word
);

  always_comb begin
    o_legal = 1'b1;
    o_word  = '0;
    unique case (i_op)
      OP_ADD:  o_word = {OPC_ADD,  i_rm, 6'b0, i_rn, i_rd};
      OP_SUB:  o_word = {OPC_SUB,  i_rm, 6'b0, i_rn, i_rd};
      OP_AND:  o_word = {OPC_AND,  i_rm, 6'b0, i_rn, i_rd};
      OP_ORR:  o_word = {OPC_ORR,  i_rm, 6'b0, i_rn, i_rd};
      OP_LDUR: o_word = {OPC_LDUR, i_dt, 2'b00, i_rn, i_rd};
      OP_STUR: o_word = {OPC_STUR, i_dt, 2'b00, i_rn, i_rd};
      OP_HALT: o_word = {OPC_HALT, 21'b0};
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_inst_encoder.sv
// Program loader: accepts mnemonic-level commands, packs them into LEGv8 words and streams
// (address, word) beats to the instruction-memory writer through a 1-deep output register.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a new program (honoured in IDLE and DONE only)
//   in_valid/in_ready     command handshake; in_op/in_rd/in_rn/in_rm/in_dt are the fields
//   out_valid/out_ready   beat handshake; out_addr/out_inst are the beat payload
//   done                  HALT beat written, program complete
//   err                   sticky illegal-op / capacity-overflow flag since the last start
//   count                 instructions emitted since start (saturates at MAX_INST)
module cpu_inst_encoder
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_INST  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [8:0]        in_dt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_inst,
  output logic              done,
  output logic              err,
  output logic [6:0]        count
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [6:0]        MaxCount = 7'(MAX_INST);
  localparam logic [6:0]        LastSlot = 7'(MAX_INST - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_next_addr;
  logic [6:0]        r_count;
  logic              r_err;
  logic              r_done;
  logic              r_halt_pend;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [31:0]       r_out_inst;

  logic        w_legal;
  logic [31:0] w_word;
  logic        w_drain;
  logic        w_accept;
  logic        w_restart;
  logic        w_is_halt;

  inst_pack u_inst_pack (
    .i_op    (in_op),
    .i_rd    (in_rd),
    .i_rn    (in_rn),
    .i_rm    (in_rm),
    .i_dt    (in_dt),
    .o_legal (w_legal),
    .o_word  (w_word)
  );

  assign w_drain   = r_out_valid && out_ready;
  // A draining beat frees the register in the same cycle, so accept can overlap the drain.
  assign in_ready  = (r_state == StLoad) && !r_halt_pend && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_restart = start && (r_state != StLoad);
  assign w_is_halt = (in_op == OP_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_next_addr <= BaseAddr;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_halt_pend <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_addr  <= BaseAddr;
      r_out_inst  <= '0;
    end else if (w_restart) begin
      r_state     <= StLoad;
      r_next_addr <= BaseAddr;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_halt_pend <= 1'b0;
    end else if (r_state == StLoad) begin
      if (w_drain) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_legal) begin
          r_out_valid <= 1'b1;
          r_out_addr  <= r_next_addr;
          r_out_inst  <= w_word;
          r_next_addr <= r_next_addr + ADDR_W'(4);
          if (r_count != MaxCount) begin
            r_count <= r_count + 7'd1;
          end
          if (w_is_halt) begin
            r_halt_pend <= 1'b1;
          end else if (r_count == LastSlot) begin
            // Last slot is reserved for HALT: keep the word, flag it, and close the program.
            r_err       <= 1'b1;
            r_halt_pend <= 1'b1;
          end
        end else begin
          r_err <= 1'b1;
        end
      end
      // in_ready is low while halt_pend, so this drain is always the final beat.
      if (r_halt_pend && w_drain) begin
        r_state     <= StDone;
        r_done      <= 1'b1;
        r_halt_pend <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_inst  = r_out_inst;
  assign done      = r_done;
  assign err       = r_err;
  assign count     = r_count;

endmodule

// File: tb/tb_cpu_inst_encoder.sv
// Self-checking bench for cpu_inst_encoder: directed scenarios plus randomized programs,
// all compared against a transaction-level model (expected-beat queue, address/count tallies).
module tb_cpu_inst_encoder;

  localparam int unsigned MaxInst = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rn;
  logic [4:0]  in_rm;
  logic [8:0]  in_dt;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_addr;
  logic [31:0] out_inst;
  logic        done;
  logic        err;
  logic [6:0]  count;

  int checks = 0;
  int errors = 0;

  cpu_inst_encoder #(
    .ADDR_W    (8),
    .BASE_ADDR (0),
    .MAX_INST  (MaxInst)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rn     (in_rn),
    .in_rm     (in_rm),
    .in_dt     (in_dt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_inst  (out_inst),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] inst;
  } beat_t;

  beat_t      exp_q[$];
  int         m_phase;      // 0 idle, 1 loading, 2 done
  logic [7:0] m_addr;
  int         m_count;
  bit         m_err;
  bit         m_halt_pend;
  int         beats_seen;
  bit         rand_ready;

  bit    mon_ov;
  bit    mon_ir;
  bit    mon_restart;
  beat_t mon_b;

  function automatic logic [31:0] enc(input int op, input int rd, input int rn,
                                      input int rm, input int dt);
    longint unsigned opc;
    longint unsigned w;
    case (op)
      0:       opc = 'h458;
      1:       opc = 'h658;
      2:       opc = 'h450;
      3:       opc = 'h550;
      4:       opc = 'h7C2;
      5:       opc = 'h7C0;
      default: opc = 'h7FF;
    endcase
    if (op <= 3)      w = opc * 2097152 + rm * 65536 + rn * 32 + rd;
    else if (op <= 5) w = opc * 2097152 + dt * 4096 + rn * 32 + rd;
    else              w = opc * 2097152;
    return w[31:0];
  endfunction

  // Inputs change just after the rising edge, so the negedge view is exactly what the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_restart = start && (m_phase != 1);
      mon_ov      = (exp_q.size() != 0);
      mon_ir      = (m_phase == 1) && !m_halt_pend && (!mon_ov || out_ready);
      checks++;
      if (out_valid !== mon_ov) begin
        errors++;
        $display("FAIL mon_out_valid: got %b want %b @%0t", out_valid, mon_ov, $time);
      end
      checks++;
      if (in_ready !== mon_ir) begin
        errors++;
        $display("FAIL mon_in_ready: got %b want %b @%0t", in_ready, mon_ir, $time);
      end
      checks++;
      if (done !== (m_phase == 2)) begin
        errors++;
        $display("FAIL mon_done: got %b want %b @%0t", done, (m_phase == 2), $time);
      end
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("FAIL mon_err: got %b want %b @%0t", err, m_err, $time);
      end
      checks++;
      if (count !== 7'(m_count)) begin
        errors++;
        $display("FAIL mon_count: got %0d want %0d @%0t", count, m_count, $time);
      end
      if (mon_ov && out_ready) begin
        mon_b = exp_q.pop_front();
        beats_seen++;
        checks++;
        if (out_addr !== mon_b.addr || out_inst !== mon_b.inst) begin
          errors++;
          $display("FAIL mon_beat: got %h@%h want %h@%h", out_inst, out_addr,
                   mon_b.inst, mon_b.addr);
        end
        if (m_halt_pend) begin
          m_phase     = 2;
          m_halt_pend = 1'b0;
        end
      end
      if (mon_ir && in_valid) begin
        if (in_op == 3'd7) begin
          m_err = 1'b1;
        end else begin
          exp_q.push_back({m_addr, enc(int'(in_op), int'(in_rd), int'(in_rn),
                                       int'(in_rm), int'(in_dt))});
          m_addr = m_addr + 8'd4;
          if (in_op == 3'd6) begin
            m_halt_pend = 1'b1;
          end else if (m_count == MaxInst - 1) begin
            m_err       = 1'b1;
            m_halt_pend = 1'b1;
          end
          if (m_count < MaxInst) m_count++;
        end
      end
      if (mon_restart) begin
        m_phase     = 1;
        m_addr      = 8'd0;
        m_count     = 0;
        m_err       = 1'b0;
        m_halt_pend = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_phase     = 0;
    m_addr      = 8'd0;
    m_count     = 0;
    m_err       = 1'b0;
    m_halt_pend = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int op, input int rd, input int rn, input int rm, input int dt);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op = 3'(op);
    in_rd = 5'(rd);
    in_rn = 5'(rn);
    in_rm = 5'(rm);
    in_dt = 9'(dt);
    for (int i = 0; i < 50; i++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) tick();
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: op %0d accepted=0 want 1", op);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #3;
    checks++;
    if ({in_ready, out_valid, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {in_ready, out_valid, done, err});
    end
    checks++;
    if (out_addr !== 8'h00 || out_inst !== 32'h0 || count !== 7'd0) begin
      errors++;
      $display("FAIL reset_regs: got addr %h inst %h count %0d want 0", out_addr, out_inst,
               count);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    do_reset();
    pulse_start();
    send(0, 1, 2, 3, 0);
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h8B030041 || out_addr !== 8'h00) begin
      errors++;
      $display("FAIL add_beat: got v%b %h@%h want v1 8b030041@00", out_valid, out_inst,
               out_addr);
    end
    checks++;
    if (count !== 7'd1) begin
      errors++;
      $display("FAIL add_count: got %0d want 1", count);
    end
  endtask

  task automatic test_load_store();
    do_reset();
    pulse_start();
    send(4, 5, 6, 0, 8);
    checks++;
    if (out_inst !== 32'hF84080C5 || out_addr !== 8'h00) begin
      errors++;
      $display("FAIL ldur_beat: got %h@%h want f84080c5@00", out_inst, out_addr);
    end
    send(5, 5, 6, 0, 8);
    checks++;
    if (out_inst !== 32'hF80080C5 || out_addr !== 8'h04) begin
      errors++;
      $display("FAIL stur_beat: got %h@%h want f80080c5@04", out_inst, out_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse_start();
    out_ready = 1'b0;
    send(0, 1, 2, 3, 0);
    in_valid = 1'b1;
    in_op = 3'd1;
    in_rd = 5'd4;
    in_rn = 5'd5;
    in_rm = 5'd6;
    in_dt = 9'd0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h8B030041 ||
          out_addr !== 8'h00) begin
        errors++;
        $display("FAIL hold: got rdy%b v%b %h@%h want rdy0 v1 8b030041@00", in_ready,
                 out_valid, out_inst, out_addr);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_accept_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_inst !== enc(1, 4, 5, 6, 0) || out_addr !== 8'h04) begin
      errors++;
      $display("FAIL sub_beat: got v%b %h@%h want v1 %h@04", out_valid, out_inst, out_addr,
               enc(1, 4, 5, 6, 0));
    end
    tick();
  endtask

  task automatic test_illegal_halt();
    do_reset();
    pulse_start();
    send(0, 1, 2, 3, 0);
    send(7, 9, 9, 9, 9);
    send(6, 0, 0, 0, 0);
    checks++;
    if (out_inst !== 32'hFFE00000 || out_addr !== 8'h04 || err !== 1'b1) begin
      errors++;
      $display("FAIL halt_beat: got %h@%h err%b want ffe00000@04 err1", out_inst, out_addr,
               err);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL halt_pend_ready: got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0 || count !== 7'd2) begin
      errors++;
      $display("FAIL halt_done: got done%b rdy%b cnt%0d want done1 rdy0 cnt2", done,
               in_ready, count);
    end
  endtask

  task automatic test_capacity();
    int b0;
    do_reset();
    b0 = beats_seen;
    pulse_start();
    for (int i = 0; i < 4; i++) send(0, i, i + 1, i + 2, 0);
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || out_addr !== 8'h0C) begin
      errors++;
      $display("FAIL cap_last: got err%b rdy%b addr%h want err1 rdy0 addr0c", err, in_ready,
               out_addr);
    end
    in_valid = 1'b1;
    in_op = 3'd0;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL cap_fifth: in_ready got %b want 0", in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || count !== 7'd4 || beats_seen - b0 !== 4) begin
      errors++;
      $display("FAIL cap_done: got done%b cnt%0d beats%0d want done1 cnt4 beats4", done,
               count, beats_seen - b0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    out_ready = 1'b0;
    send(2, 3, 4, 5, 0);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_addr !== 8'h00 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got v%b addr%h rdy%b want v0 addr00 rdy0", out_valid, out_addr,
               in_ready);
    end
    out_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || count !== 7'd0 || in_ready !== 1'b0 ||
        out_addr !== 8'h00) begin
      errors++;
      $display("FAIL rst_release: got done%b err%b cnt%0d rdy%b addr%h want idle zeros",
               done, err, count, in_ready, out_addr);
    end
    pulse_start();
    send(3, 7, 8, 9, 0);
    checks++;
    if (out_inst !== enc(3, 7, 8, 9, 0) || out_addr !== 8'h00) begin
      errors++;
      $display("FAIL rst_restart: got %h@%h want %h@00", out_inst, out_addr,
               enc(3, 7, 8, 9, 0));
    end
    tick();
  endtask

  task automatic test_random();
    int guard;
    int r;
    int op;
    do_reset();
    rand_ready = 1'b1;
    for (int p = 0; p < 30; p++) begin
      pulse_start();
      guard = 0;
      while (m_phase != 2 && guard < 60) begin
        guard++;
        if (m_halt_pend) begin
          out_ready = ($urandom_range(0, 1) != 0);
          tick();
        end else if ($urandom_range(0, 9) == 0) begin
          pulse_start();  // ignored while loading
        end else begin
          r = int'($urandom_range(0, 15));
          op = (r < 2) ? 7 : (r < 4) ? 6 : int'($urandom_range(0, 5));
          send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 511)));
        end
      end
      checks++;
      if (m_phase != 2 || done !== 1'b1) begin
        errors++;
        $display("FAIL rand_prog_end: prog %0d done got %b want 1", p, done);
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_leftover: %0d beats never seen, want 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_op = '0;
    in_rd = '0;
    in_rn = '0;
    in_rm = '0;
    in_dt = '0;
    out_ready = 1'b1;
    rand_ready = 1'b0;
    beats_seen = 0;
    model_clear();
    test_reset();
    test_add();
    test_load_store();
    test_back_to_back();
    test_illegal_halt();
    test_capacity();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
